// File: rtl/team_06_echo_delay_buffer_if.sv
// Past-sample lookup interface between the echo effect (master) and its delay buffer (slave).
// The master stores samples and issues age-indexed lookups; the slave answers one lookup at a time.
interface team_06_echo_delay_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
);
  logic              save_valid;
  logic [DATA_W-1:0] save_audio;
  logic              search;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] past_output;
  logic              search_enable;
  logic              busy;
  logic [ADDR_W:0]   fill;

  modport master (
    output save_valid, save_audio, search, offset,
    input  past_output, search_enable, busy, fill
  );

  modport slave (
    input  save_valid, save_audio, search, offset,
    output past_output, search_enable, busy, fill
  );
endinterface

// File: rtl/team_06_echo_delay_buffer.sv
// Circular delay line answering "sample written offset+1 samples ago" lookups.
// History older than the fill count reads back as silence, so memory never needs clearing.
module team_06_echo_delay_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  team_06_echo_delay_buffer_if.slave    io
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESPOND
  } state_t;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_fill;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_capture;

  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_silence;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_silence;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_past_hold;
  logic [DATA_W-1:0] w_response;

  // ---------------------------------------------------------------------------
  // Write path: runs in every FSM state, including mid-lookup.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // this is what makes same-cycle write/lookup see the old history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (io.save_valid) begin
      r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + (ADDR_W + 1)'(1);
      end
    end
  end

  // NOTE: the sample store has no reset so it maps onto block RAM; stale
  // contents are masked by the fill-count silence check instead.
  always_ff @(posedge clk) begin
    if (io.save_valid) begin
      r_mem[r_wr_ptr] <= io.save_audio;
    end
  end

  // Read port: a write to the same address on this edge leaves the old word here.
  always_ff @(posedge clk) begin
    if (r_state == S_LOOKUP) begin
      r_rd_data <= r_mem[r_rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup request decode, evaluated against pre-write pointer and fill.
  // ---------------------------------------------------------------------------
  assign w_rd_addr = r_wr_ptr - ADDR_W'(1) - io.offset;
  assign w_silence = ({1'b0, io.offset} >= r_fill);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_silence <= 1'b0;
    end else if (w_capture) begin
      r_rd_addr <= w_rd_addr;
      r_silence <= w_silence;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (io.search) begin
          w_capture    = 1'b1;
          w_state_next = S_LOOKUP;
        end
      end
      S_LOOKUP:  w_state_next = S_RESPOND;
      S_RESPOND: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response: live during RESPOND, then held until the next response.
  // ---------------------------------------------------------------------------
  assign w_response = r_silence ? '0 : r_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_past_hold <= '0;
    end else if (r_state == S_RESPOND) begin
      r_past_hold <= w_response;
    end
  end

  assign io.search_enable = (r_state == S_RESPOND);
  assign io.busy          = (r_state == S_LOOKUP);
  assign io.past_output   = io.search_enable ? w_response : r_past_hold;
  assign io.fill          = r_fill;

endmodule

// File: tb/tb_team_06_echo_delay_buffer.sv
// Directed bench for the echo delay buffer: a full-size instance plus a 16-deep one for wrap.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_team_06_echo_delay_buffer;

  localparam int DW  = 8;
  localparam int AW  = 13;
  localparam int AW4 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  team_06_echo_delay_buffer_if #(.DATA_W(DW), .ADDR_W(AW))  bus  ();
  team_06_echo_delay_buffer_if #(.DATA_W(DW), .ADDR_W(AW4)) bus4 ();

  team_06_echo_delay_buffer #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  team_06_echo_delay_buffer #(.DATA_W(DW), .ADDR_W(AW4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .io  (bus4)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Issue one lookup on the full-size instance (optionally with a same-cycle write)
  // and wait a bounded number of cycles for the response pulse.
  task automatic search_main(input logic [AW-1:0] off, input logic wr, input logic [DW-1:0] wd,
                             output int lat, output logic [DW-1:0] data, output logic busy_seen);
    @(negedge clk);
    bus.search     = 1'b1;
    bus.offset     = off;
    bus.save_valid = wr;
    bus.save_audio = wd;
    lat       = 0;
    data      = '0;
    busy_seen = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.search     = 1'b0;
        bus.save_valid = 1'b0;
        busy_seen      = bus.busy;
      end
      if (bus.search_enable) begin
        lat  = k;
        data = bus.past_output;
        break;
      end
    end
  endtask

  // Lookup on the 16-deep instance, optionally writing during the LOOKUP cycle.
  task automatic search_small(input logic [AW4-1:0] off, input logic wr_lookup, input logic [DW-1:0] wd,
                              output int lat, output logic [DW-1:0] data);
    @(negedge clk);
    bus4.search = 1'b1;
    bus4.offset = off;
    lat  = 0;
    data = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus4.search     = 1'b0;
        bus4.save_valid = wr_lookup;
        bus4.save_audio = wd;
      end
      if (k == 2) bus4.save_valid = 1'b0;
      if (bus4.search_enable) begin
        lat  = k;
        data = bus4.past_output;
        break;
      end
    end
    bus4.save_valid = 1'b0;
  endtask

  task automatic write_main(input logic [DW-1:0] d);
    @(negedge clk);
    bus.save_valid = 1'b1;
    bus.save_audio = d;
  endtask

  task automatic write_small(input logic [DW-1:0] d);
    @(negedge clk);
    bus4.save_valid = 1'b1;
    bus4.save_audio = d;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.save_valid  = 1'b0;
    bus.search      = 1'b0;
    bus4.save_valid = 1'b0;
    bus4.search     = 1'b0;
  endtask

  task automatic test_reset();
    int          lat;
    logic [DW-1:0] data;
    logic        bsy;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.fill !== 14'd0) begin n_mis++; $display("FAIL reset_fill: got %0d expected 0", bus.fill); end
    n_cmp++; if (bus.search_enable !== 1'b0) begin n_mis++; $display("FAIL reset_search_enable: got %b expected 0", bus.search_enable); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.past_output !== 8'd0) begin n_mis++; $display("FAIL reset_past_output: got %0d expected 0", bus.past_output); end
    rst = 1'b0;
    search_main(13'd0, 1'b0, 8'd0, lat, data, bsy);
    n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL empty_latency: got %0d expected 2", lat); end
    n_cmp++; if (data !== 8'd0) begin n_mis++; $display("FAIL empty_data: got %0d expected 0", data); end
    n_cmp++; if (bsy !== 1'b1) begin n_mis++; $display("FAIL empty_busy_lookup: got %b expected 1", bsy); end
    n_cmp++; if (bus.fill !== 14'd0) begin n_mis++; $display("FAIL empty_fill: got %0d expected 0", bus.fill); end
  endtask

  task automatic test_basic_lookup();
    int          lat;
    logic [DW-1:0] data;
    logic        bsy;
    logic [AW-1:0] offs [4] = '{13'd0, 13'd1, 13'd3, 13'd2};
    logic [DW-1:0] exps [4] = '{8'd30, 8'd20, 8'd0, 8'd10};
    write_main(8'd10);
    write_main(8'd20);
    write_main(8'd30);
    idle_cycle();
    n_cmp++; if (bus.fill !== 14'd3) begin n_mis++; $display("FAIL basic_fill: got %0d expected 3", bus.fill); end
    for (int i = 0; i < 4; i++) begin
      search_main(offs[i], 1'b0, 8'd0, lat, data, bsy);
      n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL basic_latency[off=%0d]: got %0d expected 2", offs[i], lat); end
      n_cmp++; if (data !== exps[i]) begin n_mis++; $display("FAIL basic_data[off=%0d]: got %0d expected %0d", offs[i], data, exps[i]); end
    end
    @(negedge clk);
    n_cmp++; if (bus.search_enable !== 1'b0) begin n_mis++; $display("FAIL basic_pulse_width: got %b expected 0", bus.search_enable); end
    n_cmp++; if (bus.past_output !== 8'd10) begin n_mis++; $display("FAIL basic_hold: got %0d expected 10", bus.past_output); end
  endtask

  task automatic test_same_cycle_write();
    int          lat;
    logic [DW-1:0] data;
    logic        bsy;
    search_main(13'd0, 1'b1, 8'd99, lat, data, bsy);
    n_cmp++; if (data !== 8'd30) begin n_mis++; $display("FAIL same_cycle_prewrite: got %0d expected 30", data); end
    search_main(13'd0, 1'b0, 8'd0, lat, data, bsy);
    n_cmp++; if (data !== 8'd99) begin n_mis++; $display("FAIL same_cycle_followup: got %0d expected 99", data); end
    n_cmp++; if (bus.fill !== 14'd4) begin n_mis++; $display("FAIL same_cycle_fill: got %0d expected 4", bus.fill); end
  endtask

  task automatic test_back_to_back();
    int          pulses;
    logic [DW-1:0] data;
    logic        busy_lookup;
    logic        busy_respond;
    pulses       = 0;
    data         = '0;
    busy_lookup  = 1'b0;
    busy_respond = 1'b1;
    @(negedge clk);
    bus.search = 1'b1;
    bus.offset = 13'd1;
    // search is held through LOOKUP and RESPOND; only the first request may be served
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) busy_lookup = bus.busy;
      if (k == 2) busy_respond = bus.busy;
      if (k == 3) bus.search = 1'b0;
      if (bus.search_enable) begin
        pulses++;
        data = bus.past_output;
      end
    end
    n_cmp++; if (pulses !== 1) begin n_mis++; $display("FAIL b2b_pulse_count: got %0d expected 1", pulses); end
    n_cmp++; if (data !== 8'd30) begin n_mis++; $display("FAIL b2b_data: got %0d expected 30", data); end
    n_cmp++; if (busy_lookup !== 1'b1) begin n_mis++; $display("FAIL b2b_busy_lookup: got %b expected 1", busy_lookup); end
    n_cmp++; if (busy_respond !== 1'b0) begin n_mis++; $display("FAIL b2b_busy_respond: got %b expected 0", busy_respond); end
  endtask

  task automatic test_wrap_small();
    int          lat;
    logic [DW-1:0] data;
    for (int i = 0; i < 20; i++) write_small(8'(i));
    idle_cycle();
    n_cmp++; if (bus4.fill !== 5'd16) begin n_mis++; $display("FAIL wrap_fill: got %0d expected 16", bus4.fill); end
    search_small(4'd0, 1'b0, 8'd0, lat, data);
    n_cmp++; if (data !== 8'd19) begin n_mis++; $display("FAIL wrap_newest: got %0d expected 19", data); end
    n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL wrap_latency: got %0d expected 2", lat); end
    // offset 15 targets the slot the next write will overwrite; write it during LOOKUP
    search_small(4'd15, 1'b1, 8'd77, lat, data);
    n_cmp++; if (data !== 8'd4) begin n_mis++; $display("FAIL wrap_oldest_collision: got %0d expected 4", data); end
    search_small(4'd0, 1'b0, 8'd0, lat, data);
    n_cmp++; if (data !== 8'd77) begin n_mis++; $display("FAIL wrap_after_collision: got %0d expected 77", data); end
    search_small(4'd15, 1'b0, 8'd0, lat, data);
    n_cmp++; if (data !== 8'd5) begin n_mis++; $display("FAIL wrap_oldest_next: got %0d expected 5", data); end
    n_cmp++; if (bus4.fill !== 5'd16) begin n_mis++; $display("FAIL wrap_fill_saturated: got %0d expected 16", bus4.fill); end
  endtask

  task automatic test_reset_mid_lookup();
    int          pulses;
    int          lat;
    logic [DW-1:0] data;
    logic        bsy;
    pulses = 0;
    @(negedge clk);
    bus.search = 1'b1;
    bus.offset = 13'd0;
    @(negedge clk);
    bus.search = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.search_enable) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_mis++; $display("FAIL abort_no_pulse: got %0d expected 0", pulses); end
    n_cmp++; if (bus.fill !== 14'd0) begin n_mis++; $display("FAIL abort_fill: got %0d expected 0", bus.fill); end
    n_cmp++; if (bus.past_output !== 8'd0) begin n_mis++; $display("FAIL abort_past_output: got %0d expected 0", bus.past_output); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    rst = 1'b0;
    search_main(13'd0, 1'b0, 8'd0, lat, data, bsy);
    n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL post_reset_latency: got %0d expected 2", lat); end
    n_cmp++; if (data !== 8'd0) begin n_mis++; $display("FAIL post_reset_data: got %0d expected 0", data); end
  endtask

  initial begin
    bus.save_valid  = 1'b0;
    bus.save_audio  = '0;
    bus.search      = 1'b0;
    bus.offset      = '0;
    bus4.save_valid = 1'b0;
    bus4.save_audio = '0;
    bus4.search     = 1'b0;
    bus4.offset     = '0;
    test_reset();
    test_basic_lookup();
    test_same_cycle_write();
    test_back_to_back();
    test_wrap_small();
    test_reset_mid_lookup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
